// File: rtl/tri_line_monitor_if.sv
// Bus bundle for tri_line_monitor.
//   master : stimulus side, drives line / trig / expect_cls, observes results
//   slave  : monitor side, samples line / trig / expect_cls, drives results
// expect_cls carries the "expect" field (expect is a reserved word in SV).
// Class encoding everywhere: 00=0, 01=1, 10=Z, 11=X.
interface tri_line_monitor_if #(
  parameter int CW = 8
);
  logic          line;
  logic          trig;
  logic [1:0]    expect_cls;
  logic [1:0]    cls;
  logic          busy;
  logic          done;
  logic          err;
  logic          timeout;
  logic [CW-1:0] latency;
  logic [CW-1:0] max_to0;
  logic [CW-1:0] max_to1;
  logic [CW-1:0] max_toZ;

  modport master (
    output line, trig, expect_cls,
    input  cls, busy, done, err, timeout, latency, max_to0, max_to1, max_toZ
  );
  modport slave (
    input  line, trig, expect_cls,
    output cls, busy, done, err, timeout, latency, max_to0, max_to1, max_toZ
  );
endinterface

// File: rtl/tri_line_monitor.sv
// tri_line_monitor: samples a tri-state line each cycle, classifies it
// (0/1/Z/X via 4-state ===), and on trig measures the cycles needed for the
// line to settle for STABLE consecutive samples at the expected class.
// Worst-case settle time per target class is kept when the optional
// TRI_MON_WORST_EN macro is defined; otherwise max_* are tied to 0.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - tri_line_monitor_if.slave: line, trig, expect_cls in;
//          cls, busy, done, err, timeout, latency, max_to0/1/Z out
// Parameters: CW counter width, STABLE settle run length, TMAX timeout.
module tri_line_monitor #(
  parameter int CW     = 8,
  parameter int STABLE = 2,
  parameter int TMAX   = 200
) (
  input logic             clk,
  input logic             rst,
  tri_line_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, FIN} state_t;

  localparam int             RW       = $clog2(STABLE + 1);
  localparam logic [CW-1:0]  TMAX_C   = CW'(TMAX);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [RW-1:0]  STABLE_C = RW'(STABLE);
  localparam logic [RW-1:0]  RUN_ONE  = RW'(1);

  state_t        state_q, state_d;
  logic [1:0]    exp_q, exp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] start_q, start_d;
  logic [RW-1:0] run_q, run_d;
  logic          fin_ld, err_d, to_d;
  logic [CW-1:0] lat_d;
  logic [1:0]    line_cls;

  // 4-state classification of the raw line
  always_comb begin
    if (bus.line === 1'b0)      line_cls = 2'b00;
    else if (bus.line === 1'b1) line_cls = 2'b01;
    else if (bus.line === 1'bz) line_cls = 2'b10;
    else                        line_cls = 2'b11;
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    run_d   = run_q;
    fin_ld  = 1'b0;
    err_d   = 1'b0;
    to_d    = 1'b0;
    lat_d   = '0;
    unique case (state_q)
      WAIT: begin
        cnt_d = (cnt_q == TMAX_C) ? cnt_q : cnt_q + CNT_ONE;
        if (bus.cls == exp_q) begin
          run_d = run_q + RUN_ONE;
          if (run_d == STABLE_C) begin
            state_d = FIN;
            fin_ld  = 1'b1;
            lat_d   = start_q;
          end
        end else begin
          // candidate run can begin no earlier than the next WAIT cycle
          run_d   = '0;
          start_d = cnt_d;
        end
        // settling on the last allowed cycle wins over timeout
        if (state_d != FIN && cnt_d == TMAX_C) begin
          state_d = FIN;
          fin_ld  = 1'b1;
          err_d   = 1'b1;
          to_d    = 1'b1;
          lat_d   = TMAX_C;
        end
      end
      FIN:     state_d = IDLE;
      default: ;
    endcase
    // trig overrides everything: aborts a WAIT silently, and in FIN the
    // done pulse still shows because done decodes the current state
    if (bus.trig) begin
      exp_d   = bus.expect_cls;
      cnt_d   = '0;
      start_d = '0;
      run_d   = '0;
      fin_ld  = 1'b0;
      err_d   = 1'b0;
      to_d    = 1'b0;
      lat_d   = '0;
      if (bus.expect_cls == 2'b11) begin
        state_d = FIN;
        fin_ld  = 1'b1;
        err_d   = 1'b1;
      end else begin
        state_d = WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      exp_q       <= 2'b00;
      cnt_q       <= '0;
      start_q     <= '0;
      run_q       <= '0;
      bus.cls     <= 2'b00;
      bus.err     <= 1'b0;
      bus.timeout <= 1'b0;
      bus.latency <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      run_q   <= run_d;
      bus.cls <= line_cls;
      if (fin_ld) begin
        bus.err     <= err_d;
        bus.timeout <= to_d;
        bus.latency <= lat_d;
      end
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == FIN);

`ifdef TRI_MON_WORST_EN
  // updates on the edge that leaves FIN, so exp_q is still this measurement's
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.max_to0 <= '0;
      bus.max_to1 <= '0;
      bus.max_toZ <= '0;
    end else if (state_q == FIN && !bus.err) begin
      case (exp_q)
        2'b00:   if (bus.latency > bus.max_to0) bus.max_to0 <= bus.latency;
        2'b01:   if (bus.latency > bus.max_to1) bus.max_to1 <= bus.latency;
        2'b10:   if (bus.latency > bus.max_toZ) bus.max_toZ <= bus.latency;
        default: ;
      endcase
    end
  end
`else
  assign bus.max_to0 = '0;
  assign bus.max_to1 = '0;
  assign bus.max_toZ = '0;
`endif
endmodule
